// File: rtl/crop_job_scheduler.sv
// crop_job_scheduler: round-robin crop job arbiter and frame sequencer.
// Optional watchdog enabled by defining CROP_SCHED_TIMEOUT_EN.
module crop_job_scheduler #(
  parameter int IN_ROWS          = 40,
  parameter int IN_COLS          = 40,
  parameter int OUT_ROWS         = 20,
  parameter int OUT_COLS         = 20,
  parameter int IMG_ROW_BITWIDTH = 10,
  parameter int IMG_COL_BITWIDTH = 10,
  parameter int CNT_BITWIDTH     = 16,
  parameter int TIMEOUT_CYCLES   = 4096
) (
  input  logic                        clk,
  input  logic                        reset,
  input  logic [IMG_ROW_BITWIDTH-1:0] req0_Y1_TDATA,
  input  logic [IMG_COL_BITWIDTH-1:0] req0_X1_TDATA,
  input  logic                        req0_TVALID,
  output logic                        req0_TREADY,
  input  logic [IMG_ROW_BITWIDTH-1:0] req1_Y1_TDATA,
  input  logic [IMG_COL_BITWIDTH-1:0] req1_X1_TDATA,
  input  logic                        req1_TVALID,
  output logic                        req1_TREADY,
  output logic [IMG_ROW_BITWIDTH-1:0] crop_Y1_TDATA,
  output logic                        crop_Y1_TVALID,
  input  logic                        crop_Y1_TREADY,
  output logic [IMG_COL_BITWIDTH-1:0] crop_X1_TDATA,
  output logic                        crop_X1_TVALID,
  input  logic                        crop_X1_TREADY,
  input  logic                        mon_in_TVALID,
  input  logic                        mon_in_TREADY,
  input  logic                        mon_out_TVALID,
  input  logic                        mon_out_TREADY,
  output logic                        busy,
  output logic                        done,
  output logic                        done_id,
  output logic                        done_clamped,
  output logic                        done_timeout
);

  localparam logic [IMG_ROW_BITWIDTH-1:0] Y_MAX =
    IMG_ROW_BITWIDTH'(IN_ROWS - OUT_ROWS);
  localparam logic [IMG_COL_BITWIDTH-1:0] X_MAX =
    IMG_COL_BITWIDTH'(IN_COLS - OUT_COLS);
  localparam logic [CNT_BITWIDTH-1:0] IN_TGT =
    CNT_BITWIDTH'(IN_ROWS * IN_COLS);
  localparam logic [CNT_BITWIDTH-1:0] OUT_TGT =
    CNT_BITWIDTH'(OUT_ROWS * OUT_COLS);

  typedef enum logic [1:0] {IDLE, CFG, RUN, DONE} state_t;

  state_t                      state;
  logic                        last_grant;
  logic                        owner;
  logic                        clamped;
  logic [CNT_BITWIDTH-1:0]     in_cnt;
  logic [CNT_BITWIDTH-1:0]     out_cnt;
  logic                        pick1;
  logic                        accept;
  logic                        y_hs;
  logic                        x_hs;
  logic                        in_hs;
  logic                        out_hs;
  logic                        cfg_done;
  logic                        frame_done;
  logic                        counting;
  logic                        timeout;
  logic                        y_over;
  logic                        x_over;
  logic [IMG_ROW_BITWIDTH-1:0] y_sel;
  logic [IMG_COL_BITWIDTH-1:0] x_sel;

  // Arbitration, handshake decode and clamp detection.
  // TREADY is gated by reset so it reads 0 while reset is held.
  always_comb begin
    pick1 = req1_TVALID & (~req0_TVALID | ~last_grant);
    req0_TREADY = reset & (state == IDLE) & req0_TVALID & ~pick1;
    req1_TREADY = reset & (state == IDLE) & pick1;
    accept = req0_TREADY | req1_TREADY;
    y_hs = crop_Y1_TVALID & crop_Y1_TREADY;
    x_hs = crop_X1_TVALID & crop_X1_TREADY;
    in_hs = mon_in_TVALID & mon_in_TREADY;
    out_hs = mon_out_TVALID & mon_out_TREADY;
    cfg_done = (~crop_Y1_TVALID | y_hs) & (~crop_X1_TVALID | x_hs);
    frame_done = (in_cnt == IN_TGT) & (out_cnt == OUT_TGT);
    counting = (state == CFG) | (state == RUN);
    y_sel = pick1 ? req1_Y1_TDATA : req0_Y1_TDATA;
    x_sel = pick1 ? req1_X1_TDATA : req0_X1_TDATA;
    y_over = y_sel > Y_MAX;
    x_over = x_sel > X_MAX;
  end

`ifdef CROP_SCHED_TIMEOUT_EN
  localparam int WD_W = $clog2(TIMEOUT_CYCLES + 1);
  logic [WD_W-1:0] wd;
  logic            any_hs;

  assign any_hs = y_hs | x_hs | in_hs | out_hs;
  assign timeout = counting & ~any_hs &
                   (wd == WD_W'(TIMEOUT_CYCLES - 1));

  // Idle-cycle watchdog; cleared by any handshake or outside a job.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) wd <= '0;
    else if (!counting || any_hs) wd <= '0;
    else wd <= wd + 1'b1;
  end

  // Timeout flag rides along with the done pulse.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) done_timeout <= 1'b0;
    else done_timeout <= timeout;
  end
`else
  assign timeout = 1'b0;
  assign done_timeout = 1'b0;
`endif

  // Job FSM with registered config streams, counters and status.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state <= IDLE;
      last_grant <= 1'b1;
      owner <= 1'b0;
      clamped <= 1'b0;
      in_cnt <= '0;
      out_cnt <= '0;
      crop_Y1_TDATA <= '0;
      crop_X1_TDATA <= '0;
      crop_Y1_TVALID <= 1'b0;
      crop_X1_TVALID <= 1'b0;
      busy <= 1'b0;
      done <= 1'b0;
      done_id <= 1'b0;
      done_clamped <= 1'b0;
    end else begin
      done <= 1'b0;
      if (counting) begin
        if (in_hs && in_cnt != IN_TGT) in_cnt <= in_cnt + 1'b1;
        if (out_hs && out_cnt != OUT_TGT) out_cnt <= out_cnt + 1'b1;
      end
      unique case (state)
        IDLE: begin
          if (accept) begin
            crop_Y1_TDATA <= y_over ? Y_MAX : y_sel;
            crop_X1_TDATA <= x_over ? X_MAX : x_sel;
            clamped <= y_over | x_over;
            owner <= pick1;
            last_grant <= pick1;
            busy <= 1'b1;
            crop_Y1_TVALID <= 1'b1;
            crop_X1_TVALID <= 1'b1;
            state <= CFG;
          end
        end
        CFG: begin
          if (y_hs) crop_Y1_TVALID <= 1'b0;
          if (x_hs) crop_X1_TVALID <= 1'b0;
          if (timeout) begin
            crop_Y1_TVALID <= 1'b0;
            crop_X1_TVALID <= 1'b0;
            done <= 1'b1;
            done_id <= owner;
            done_clamped <= clamped;
            state <= DONE;
          end else if (cfg_done) begin
            state <= RUN;
          end
        end
        RUN: begin
          if (timeout || frame_done) begin
            done <= 1'b1;
            done_id <= owner;
            done_clamped <= clamped;
            state <= DONE;
          end
        end
        DONE: begin
          busy <= 1'b0;
          in_cnt <= '0;
          out_cnt <= '0;
          state <= IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_crop_job_scheduler.sv
// tb_crop_job_scheduler: directed self-checking bench for crop_job_scheduler.
// Timeout scenario runs only when CROP_SCHED_TIMEOUT_EN is defined.
module tb_crop_job_scheduler;

  logic       clk = 1'b0;
  logic       reset;
  logic [9:0] req0_Y1_TDATA, req1_Y1_TDATA;
  logic [9:0] req0_X1_TDATA, req1_X1_TDATA;
  logic       req0_TVALID, req0_TREADY, req1_TVALID, req1_TREADY;
  logic [9:0] crop_Y1_TDATA, crop_X1_TDATA;
  logic       crop_Y1_TVALID, crop_Y1_TREADY;
  logic       crop_X1_TVALID, crop_X1_TREADY;
  logic       mon_in_TVALID, mon_in_TREADY;
  logic       mon_out_TVALID, mon_out_TREADY;
  logic       busy, done, done_id, done_clamped, done_timeout;

  int n_cmp = 0;
  int n_err = 0;

  logic       obs_rdy0, obs_rdy1, obs_vy, obs_vx, obs_busy;
  logic [9:0] obs_y, obs_x;
  logic       obs_vdrop, obs_rdy_busy, obs_early;
  logic       obs_done, obs_id, obs_cl, obs_to, obs_done2, obs_busy2;

  crop_job_scheduler #(.TIMEOUT_CYCLES(16)) dut (
    .clk(clk), .reset(reset),
    .req0_Y1_TDATA(req0_Y1_TDATA), .req0_X1_TDATA(req0_X1_TDATA),
    .req0_TVALID(req0_TVALID), .req0_TREADY(req0_TREADY),
    .req1_Y1_TDATA(req1_Y1_TDATA), .req1_X1_TDATA(req1_X1_TDATA),
    .req1_TVALID(req1_TVALID), .req1_TREADY(req1_TREADY),
    .crop_Y1_TDATA(crop_Y1_TDATA), .crop_Y1_TVALID(crop_Y1_TVALID),
    .crop_Y1_TREADY(crop_Y1_TREADY),
    .crop_X1_TDATA(crop_X1_TDATA), .crop_X1_TVALID(crop_X1_TVALID),
    .crop_X1_TREADY(crop_X1_TREADY),
    .mon_in_TVALID(mon_in_TVALID), .mon_in_TREADY(mon_in_TREADY),
    .mon_out_TVALID(mon_out_TVALID), .mon_out_TREADY(mon_out_TREADY),
    .busy(busy), .done(done), .done_id(done_id),
    .done_clamped(done_clamped), .done_timeout(done_timeout)
  );

  always #5 clk = ~clk;

  task automatic step();
    @(posedge clk);
    #2;
  endtask

  task automatic apply_reset();
    reset = 1'b0;
    step();
    step();
    reset = 1'b1;
  endtask

  // Drives one full job (request already presented by the caller) and
  // records what the DUT showed at each stage.
  task automatic run_job();
    crop_Y1_TREADY = 1'b1;
    crop_X1_TREADY = 1'b1;
    #1;
    obs_rdy0 = req0_TREADY;
    obs_rdy1 = req1_TREADY;
    step();
    obs_vy = crop_Y1_TVALID & crop_X1_TVALID;
    obs_y = crop_Y1_TDATA;
    obs_x = crop_X1_TDATA;
    obs_busy = busy;
    step();
    obs_vdrop = crop_Y1_TVALID | crop_X1_TVALID;
    obs_rdy_busy = 1'b0;
    obs_early = 1'b0;
    for (int i = 0; i < 1600; i++) begin
      mon_in_TVALID = 1'b1;
      mon_out_TVALID = (i < 400);
      #1;
      obs_rdy_busy |= req0_TREADY | req1_TREADY;
      step();
      obs_early |= done;
    end
    mon_in_TVALID = 1'b0;
    mon_out_TVALID = 1'b0;
    step();
    obs_done = done;
    obs_id = done_id;
    obs_cl = done_clamped;
    obs_to = done_timeout;
    step();
    obs_done2 = done;
    obs_busy2 = busy;
  endtask

  task automatic test_reset();
    reset = 1'b1;
    req0_TVALID = 1'b1;
    req1_TVALID = 1'b0;
    req0_Y1_TDATA = '0; req0_X1_TDATA = '0;
    req1_Y1_TDATA = '0; req1_X1_TDATA = '0;
    crop_Y1_TREADY = 1'b0; crop_X1_TREADY = 1'b0;
    mon_in_TVALID = 1'b0; mon_in_TREADY = 1'b1;
    mon_out_TVALID = 1'b0; mon_out_TREADY = 1'b1;
    #3 reset = 1'b0;
    #1;
    n_cmp++;
    if ({busy, done, done_id, done_clamped, done_timeout} !== 5'b0) begin
      n_err++;
      $display("FAIL reset_status: got %b want 00000",
               {busy, done, done_id, done_clamped, done_timeout});
    end
    n_cmp++;
    if ({crop_Y1_TVALID, crop_X1_TVALID} !== 2'b0) begin
      n_err++;
      $display("FAIL reset_crop_valid: got %b want 00",
               {crop_Y1_TVALID, crop_X1_TVALID});
    end
    n_cmp++;
    if ({req0_TREADY, req1_TREADY} !== 2'b0) begin
      n_err++;
      $display("FAIL reset_tready: got %b want 00",
               {req0_TREADY, req1_TREADY});
    end
    req0_TVALID = 1'b0;
    step();
    step();
    reset = 1'b1;
    step();
  endtask

  task automatic test_single_job();
    req0_Y1_TDATA = 10'd5;
    req0_X1_TDATA = 10'd7;
    req0_TVALID = 1'b1;
    run_job();
    req0_TVALID = 1'b0;
    n_cmp++;
    if ({obs_rdy0, obs_rdy1} !== 2'b10) begin
      n_err++;
      $display("FAIL single_grant: got %b want 10", {obs_rdy0, obs_rdy1});
    end
    n_cmp++;
    if (obs_y !== 10'd5 || obs_x !== 10'd7 || obs_vy !== 1'b1) begin
      n_err++;
      $display("FAIL single_cfg: got y=%0d x=%0d v=%b want 5 7 1",
               obs_y, obs_x, obs_vy);
    end
    n_cmp++;
    if (obs_busy !== 1'b1 || obs_vdrop !== 1'b0) begin
      n_err++;
      $display("FAIL single_busy_drop: got %b%b want 10",
               obs_busy, obs_vdrop);
    end
    n_cmp++;
    if (obs_early !== 1'b0 || obs_done !== 1'b1) begin
      n_err++;
      $display("FAIL single_done_timing: early=%b done=%b want 0 1",
               obs_early, obs_done);
    end
    n_cmp++;
    if ({obs_id, obs_cl, obs_to} !== 3'b000) begin
      n_err++;
      $display("FAIL single_done_info: got %b want 000",
               {obs_id, obs_cl, obs_to});
    end
    n_cmp++;
    if ({obs_done2, obs_busy2} !== 2'b00) begin
      n_err++;
      $display("FAIL single_after_done: got %b want 00",
               {obs_done2, obs_busy2});
    end
  endtask

  task automatic test_clamp();
    req1_Y1_TDATA = 10'd30;
    req1_X1_TDATA = 10'd25;
    req1_TVALID = 1'b1;
    run_job();
    req1_TVALID = 1'b0;
    n_cmp++;
    if ({obs_rdy0, obs_rdy1} !== 2'b01) begin
      n_err++;
      $display("FAIL clamp_grant: got %b want 01", {obs_rdy0, obs_rdy1});
    end
    n_cmp++;
    if (obs_y !== 10'd20 || obs_x !== 10'd20) begin
      n_err++;
      $display("FAIL clamp_data: got y=%0d x=%0d want 20 20", obs_y, obs_x);
    end
    n_cmp++;
    if ({obs_done, obs_id, obs_cl} !== 3'b111) begin
      n_err++;
      $display("FAIL clamp_done: got %b want 111",
               {obs_done, obs_id, obs_cl});
    end
  endtask

  task automatic test_arbitration();
    logic [2:0] ids, cls, r0s, r1s, bad;
    apply_reset();
    req0_Y1_TDATA = 10'd20; req0_X1_TDATA = 10'd20;
    req1_Y1_TDATA = 10'd21; req1_X1_TDATA = 10'd0;
    req0_TVALID = 1'b1;
    req1_TVALID = 1'b1;
    bad = '0;
    for (int j = 0; j < 3; j++) begin
      run_job();
      ids[j] = obs_id;
      cls[j] = obs_cl;
      r0s[j] = obs_rdy0;
      r1s[j] = obs_rdy1;
      bad[j] = obs_rdy_busy | obs_early | ~obs_done;
    end
    req0_TVALID = 1'b0;
    req1_TVALID = 1'b0;
    n_cmp++;
    if (ids !== 3'b010) begin
      n_err++;
      $display("FAIL arb_order: got ids(j2..j0)=%b want 010", ids);
    end
    n_cmp++;
    if (r0s !== 3'b101 || r1s !== 3'b010) begin
      n_err++;
      $display("FAIL arb_tready: got r0=%b r1=%b want 101 010", r0s, r1s);
    end
    n_cmp++;
    if (cls !== 3'b010) begin
      n_err++;
      $display("FAIL arb_clamp_edge: got %b want 010", cls);
    end
    n_cmp++;
    if (bad !== 3'b000) begin
      n_err++;
      $display("FAIL arb_busy_tready: got %b want 000", bad);
    end
  endtask

  task automatic test_skewed_cfg();
    int vx_cnt, vy_cnt;
    logic data_bad, saw_done;
    req0_Y1_TDATA = 10'd3;
    req0_X1_TDATA = 10'd4;
    req0_TVALID = 1'b1;
    crop_Y1_TREADY = 1'b1;
    crop_X1_TREADY = 1'b0;
    step();
    req0_TVALID = 1'b0;
    vx_cnt = 0; vy_cnt = 0;
    data_bad = 1'b0; saw_done = 1'b0;
    for (int i = 0; i < 1600; i++) begin
      mon_in_TVALID = 1'b1;
      mon_out_TVALID = (i < 400);
      crop_X1_TREADY = (i >= 3);
      if (crop_X1_TVALID) begin
        vx_cnt++;
        if (crop_X1_TDATA !== 10'd4) data_bad = 1'b1;
      end
      if (crop_Y1_TVALID) vy_cnt++;
      step();
      saw_done |= done;
    end
    mon_in_TVALID = 1'b0;
    mon_out_TVALID = 1'b0;
    n_cmp++;
    if (vy_cnt != 1 || vx_cnt != 4) begin
      n_err++;
      $display("FAIL skew_valid_len: got y=%0d x=%0d want 1 4",
               vy_cnt, vx_cnt);
    end
    n_cmp++;
    if (data_bad !== 1'b0 || saw_done !== 1'b0) begin
      n_err++;
      $display("FAIL skew_hold: data_bad=%b early_done=%b want 0 0",
               data_bad, saw_done);
    end
    step();
    n_cmp++;
    if (done !== 1'b1 || done_id !== 1'b0) begin
      n_err++;
      $display("FAIL skew_done: got %b%b want 10", done, done_id);
    end
    step();
  endtask

  task automatic test_mid_reset();
    logic saw;
    req0_Y1_TDATA = 10'd5;
    req0_X1_TDATA = 10'd7;
    req0_TVALID = 1'b1;
    crop_Y1_TREADY = 1'b1;
    crop_X1_TREADY = 1'b0;
    step();
    req0_TVALID = 1'b0;
    for (int i = 0; i < 800; i++) begin
      mon_in_TVALID = 1'b1;
      step();
    end
    mon_in_TVALID = 1'b0;
    req0_TVALID = 1'b1;
    #1 reset = 1'b0;
    #1;
    n_cmp++;
    if ({busy, done, crop_Y1_TVALID, crop_X1_TVALID} !== 4'b0) begin
      n_err++;
      $display("FAIL midrst_outputs: got %b want 0000",
               {busy, done, crop_Y1_TVALID, crop_X1_TVALID});
    end
    n_cmp++;
    if ({req0_TREADY, req1_TREADY} !== 2'b0) begin
      n_err++;
      $display("FAIL midrst_tready: got %b want 00",
               {req0_TREADY, req1_TREADY});
    end
    saw = 1'b0;
    for (int i = 0; i < 3; i++) begin
      step();
      saw |= done;
    end
    reset = 1'b1;
    n_cmp++;
    if (saw !== 1'b0) begin
      n_err++;
      $display("FAIL midrst_no_done: got %b want 0", saw);
    end
    run_job();
    req0_TVALID = 1'b0;
    n_cmp++;
    if (obs_rdy0 !== 1'b1 || obs_y !== 10'd5 || obs_x !== 10'd7) begin
      n_err++;
      $display("FAIL midrst_regrant: got rdy=%b y=%0d x=%0d want 1 5 7",
               obs_rdy0, obs_y, obs_x);
    end
    n_cmp++;
    if (obs_early !== 1'b0 || obs_done !== 1'b1 || obs_id !== 1'b0) begin
      n_err++;
      $display("FAIL midrst_job: early=%b done=%b id=%b want 0 1 0",
               obs_early, obs_done, obs_id);
    end
  endtask

`ifdef CROP_SCHED_TIMEOUT_EN
  task automatic test_timeout();
    logic early;
    apply_reset();
    req0_Y1_TDATA = 10'd1;
    req0_X1_TDATA = 10'd2;
    req0_TVALID = 1'b1;
    crop_Y1_TREADY = 1'b1;
    crop_X1_TREADY = 1'b1;
    step();
    req0_TVALID = 1'b0;
    step();
    for (int i = 0; i < 100; i++) begin
      mon_in_TVALID = 1'b1;
      mon_out_TVALID = 1'b1;
      step();
    end
    mon_in_TVALID = 1'b0;
    mon_out_TVALID = 1'b0;
    early = 1'b0;
    for (int k = 1; k < 16; k++) begin
      step();
      early |= done;
    end
    step();
    n_cmp++;
    if (early !== 1'b0 || done !== 1'b1 || done_timeout !== 1'b1) begin
      n_err++;
      $display("FAIL timeout_done: early=%b done=%b to=%b want 0 1 1",
               early, done, done_timeout);
    end
    step();
    n_cmp++;
    if ({busy, done, done_timeout} !== 3'b000) begin
      n_err++;
      $display("FAIL timeout_after: got %b want 000",
               {busy, done, done_timeout});
    end
  endtask
`endif

  initial begin
    test_reset();
    test_single_job();
    test_clamp();
    test_arbitration();
    test_skewed_cfg();
    test_mid_reset();
`ifdef CROP_SCHED_TIMEOUT_EN
    test_timeout();
`endif
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule

// File: doc/crop_job_scheduler.md
Name: crop_job_scheduler

Overview:
Sequences the crop_plus_fifo datapath between two independent crop requesters. Round-robin arbitrates crop-window requests and clamps each window to the legal range. Programs the crop_Y1/crop_X1 config streams, then monitors input and output pixel handshakes until the frame completes. Signals completion before granting the next request. Sits directly upstream of the crop config ports; pixel data does not pass through it.

Parameters:
IN_ROWS, 40, input frame rows
IN_COLS, 40, input frame columns
OUT_ROWS, 20, crop window rows
OUT_COLS, 20, crop window columns
IMG_ROW_BITWIDTH, 10, width of row coordinates
IMG_COL_BITWIDTH, 10, width of column coordinates
CNT_BITWIDTH, 16, pixel counter width; must hold IN_ROWS*IN_COLS
TIMEOUT_CYCLES, 4096, watchdog limit (optional feature only)

Ports:
clk  in  1  clock
reset  in  1  asynchronous, active-low reset
req0_Y1_TDATA  in  IMG_ROW_BITWIDTH  requester 0 top row
req0_X1_TDATA  in  IMG_COL_BITWIDTH  requester 0 left column
req0_TVALID / req0_TREADY  in/out  1  requester 0 handshake
req1_Y1_TDATA, req1_X1_TDATA, req1_TVALID, req1_TREADY  as requester 0
crop_Y1_TDATA  out  IMG_ROW_BITWIDTH  to crop config
crop_Y1_TVALID / crop_Y1_TREADY  out/in  1
crop_X1_TDATA  out  IMG_COL_BITWIDTH  to crop config
crop_X1_TVALID / crop_X1_TREADY  out/in  1
mon_in_TVALID, mon_in_TREADY  in  1  tap of datapath pixel_in handshake
mon_out_TVALID, mon_out_TREADY  in  1  tap of datapath pixel_out handshake
busy  out  1  a job is in progress
done  out  1  one-cycle job-complete pulse
done_id  out  1  requester that owned the finished job
done_clamped  out  1  the job's coordinates were clamped
done_timeout  out  1  the job ended by watchdog

Behaviour:
- Reset (reset=0, async): state=IDLE; all TVALID/TREADY outputs 0; busy, done, done_id, done_clamped, done_timeout = 0; counters 0; last_grant=1, so requester 0 wins the first tie.
- FSM states: IDLE, CFG, RUN, DONE.
- IDLE arbitration:
  - If exactly one reqN_TVALID is high, grant N.
  - If both are high, grant the requester that is not last_grant.
  - reqN_TREADY is combinational: high only in IDLE for the granted N.
  - On acceptance: latch coordinates, update last_grant, set busy, go to CFG next cycle. Acceptance-to-crop_*_TVALID latency is 1 cycle.
- Clamping at latch:
  - Y1 > IN_ROWS-OUT_ROWS → Y1 := IN_ROWS-OUT_ROWS.
  - X1 > IN_COLS-OUT_COLS → X1 := IN_COLS-OUT_COLS.
  - Either clamp sets the job's clamped flag.
- CFG:
  - crop_Y1_TVALID and crop_X1_TVALID rise together.
  - Each drops independently the cycle after its own handshake.
  - TDATA holds stable while its TVALID is high.
  - Move to RUN once both handshakes have completed; same-cycle completion is allowed.
- Pixel counting starts on entry to CFG:
  - in_cnt increments on each mon_in_TVALID&mon_in_TREADY cycle.
  - out_cnt increments on each mon_out_TVALID&mon_out_TREADY cycle.
  - Each counter saturates at its target: IN_ROWS*IN_COLS for in_cnt, OUT_ROWS*OUT_COLS for out_cnt.
- RUN → DONE when both counters are at target, including when both reach target in the same cycle.
- DONE:
  - done=1 for exactly one cycle with done_id, done_clamped, done_timeout valid.
  - Clear counters and busy; return to IDLE.
  - The next grant can be accepted on the following cycle.
- Requests arriving while busy are not accepted; requesters hold TVALID.
- Reset asserted mid-job abandons the job immediately with no done pulse.

Optional Feature:
CROP_SCHED_TIMEOUT_EN:
- Defined: in CFG or RUN, a watchdog counts cycles with no config or pixel handshake and clears on any handshake. Reaching TIMEOUT_CYCLES forces DONE with done_timeout=1 and drops any pending crop_*_TVALID.
- Undefined: no watchdog logic; done_timeout is tied to 0.

Test Plan:
- Single job: req0 (Y1=5, X1=7); crop TREADY=1; 1600 in-handshakes, 400 out-handshakes → crop TDATA 5/7 one cycle after acceptance; done pulse with done_id=0, clamped=0; busy low after done.
- Clamp: req1 (Y1=30, X1=25) → crop_Y1_TDATA=20, crop_X1_TDATA=20, done_clamped=1.
- Arbitration: both valid from reset, back-to-back jobs → grants in order 0, 1, 0; the unserved TREADY stays low during each job.
- Skewed config: crop_X1_TREADY delayed 3 cycles after crop_Y1 → Y1_TVALID drops after 1 cycle, X1_TVALID holds 4 cycles; RUN entered only after both handshakes.
- Mid-job reset after 800 input pixels → all outputs 0 asynchronously; no done pulse; a new req0 is accepted cleanly.
- With CROP_SCHED_TIMEOUT_EN, TIMEOUT_CYCLES=16: stall mon_out after 100 output pixels → done with done_timeout=1 exactly 16 idle cycles later.
